hs_status_probe: RTL

HS_STATUS_PROBE -- requirements
Module: hs_status_probe

---
 rtl/hs_probe_pkg.sv | 24 ++
 rtl/hs_probe_fifo.sv | 67 ++++++
 rtl/hs_status_probe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hs_probe_pkg.sv
// Shared types for hs_status_probe: FSM state encoding, record layout and fixed field widths.
package hs_probe_pkg;

  localparam int ID_W      = 4;
  localparam int DROP_W    = 16;
  localparam int REC_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE_WAIT,
    ST_STOPPED
  } state_e;

  // rec_data is this struct flattened, MSB first, when CNT_W is left at its default.
  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [REC_CNT_W-1:0] start_cyc;
    logic [REC_CNT_W-1:0] latency;
    logic [REC_CNT_W-1:0] interval;
    logic                 incomplete;
  } rec_t;

endpackage

// File: rtl/hs_probe_fifo.sv
// Synchronous record FIFO with a registered head; a push into a full FIFO lands only if a pop
// happens in the same cycle.
module hs_probe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_count_next;

  assign o_full       = (r_count == FULL_CNT);
  assign o_empty      = (r_count == '0);
  assign o_head       = r_head;
  assign w_do_pop     = i_pop && !o_empty;
  assign w_do_push    = i_push && (!o_full || w_do_pop);
  assign w_rd_next    = r_rd_ptr + AW'(w_do_pop);
  assign w_count_next = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // The head register tracks the entry at the next read pointer, bypassing a push into an empty slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_count_next == '0) begin
        r_head <= '0;
      end else if (w_do_push && (r_wr_ptr == w_rd_next)) begin
        r_head <= i_data;
      end else begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

endmodule

// File: rtl/hs_status_probe.sv
// Observes an ap_start/ap_done/ap_continue handshake and streams per-transaction timing records.
// Define HS_PROBE_INTERVAL_EN to measure start-to-start intervals; otherwise the field reads 0.
module hs_status_probe
  import hs_probe_pkg::*;
#(
  parameter int MOD_ID     = 0,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic                  ap_continue,
  input  logic                  finish,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [ID_W+3*CNT_W:0] rec_data,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]      txn_cnt,
  output logic                  busy
);

  localparam int                REC_W   = ID_W + 3*CNT_W + 1;
  localparam logic [ID_W-1:0]   ID      = ID_W'(MOD_ID);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_e            r_state;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_start_cyc;
  logic [CNT_W-1:0]  r_txn_cnt;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_unused_ready;
  logic              w_start_evt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_incomplete;
  logic [CNT_W-1:0]  w_rec_start;
  logic [CNT_W-1:0]  w_latency;
  logic [CNT_W-1:0]  w_interval;
  logic [REC_W-1:0]  w_rec;

  assign w_unused_ready = ap_ready;
  assign w_start_evt    = (r_state == ST_IDLE) && ap_start && !finish;
  assign rec_valid      = !w_empty;
  assign w_pop          = rec_valid && rec_ready;
  assign w_rec          = {ID, w_rec_start, w_latency, w_interval, w_incomplete};
  assign drop_cnt       = r_drop_cnt;
  assign txn_cnt        = r_txn_cnt;
  assign busy           = r_busy;

  // cyc saturates and never falls behind start_cyc, so the difference cannot wrap.
  always_comb begin
    w_push       = 1'b0;
    w_incomplete = 1'b0;
    w_rec_start  = r_start_cyc;
    w_latency    = r_cyc - r_start_cyc;
    case (r_state)
      ST_IDLE: begin
        if (w_start_evt && ap_done) begin
          w_push      = 1'b1;
          w_rec_start = r_cyc;
          w_latency   = '0;
        end
      end
      ST_RUN: begin
        if (finish) begin
          w_push       = 1'b1;
          w_incomplete = 1'b1;
        end else if (ap_done) begin
          w_push = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef HS_PROBE_INTERVAL_EN
  logic [CNT_W-1:0] r_prev_start;
  logic             r_prev_valid;

  always_comb begin
    w_interval = '0;
    if (r_state == ST_IDLE) begin
      if (r_txn_cnt != '0) begin
        w_interval = r_cyc - r_start_cyc;
      end
    end else if (r_prev_valid) begin
      w_interval = r_start_cyc - r_prev_start;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_prev_start <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_start_evt) begin
      r_prev_start <= r_start_cyc;
      r_prev_valid <= (r_txn_cnt != '0);
    end
  end
`else
  assign w_interval = '0;
`endif

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_cyc       <= '0;
      r_start_cyc <= '0;
      r_txn_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_cyc != CNT_MAX) begin
        r_cyc <= r_cyc + CNT_W'(1);
      end
      if (w_start_evt) begin
        r_start_cyc <= r_cyc;
        if (r_txn_cnt != CNT_MAX) begin
          r_txn_cnt <= r_txn_cnt + CNT_W'(1);
        end
      end
      if (w_push && w_full && !w_pop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
      if (finish) begin
        r_state <= ST_STOPPED;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (ap_start && !ap_done) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (ap_done) begin
              r_state <= ap_continue ? ST_IDLE : ST_DONE_WAIT;
              r_busy  <= !ap_continue;
            end
          end
          ST_DONE_WAIT: begin
            if (ap_continue) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  hs_probe_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (rec_data)
  );

endmodule
